// File: rtl/regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: read ports, issue, two write-back ports, error.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            iss_en_i;
  logic [AW-1:0]   iss_rd_i;
  logic            wb0_en_i;
  logic [AW-1:0]   wb0_addr_i;
  logic [XLEN-1:0] wb0_data_i;
  logic            wb1_en_i;
  logic [AW-1:0]   wb1_addr_i;
  logic [XLEN-1:0] wb1_data_i;
  logic            err_o;

  modport slave (
    input  rs1_addr_i, rs2_addr_i, iss_en_i, iss_rd_i,
    input  wb0_en_i, wb0_addr_i, wb0_data_i, wb1_en_i, wb1_addr_i, wb1_data_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o
  );

  modport master (
    output rs1_addr_i, rs2_addr_i, iss_en_i, iss_rd_i,
    output wb0_en_i, wb0_addr_i, wb0_data_i, wb1_en_i, wb1_addr_i, wb1_data_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, err_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, write-back forwarding and sticky error flag.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave rf
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_set;
  logic            wb0_v, wb1_v, iss_v;

  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;

  assign wb0_v = rf.wb0_en_i && (rf.wb0_addr_i != '0);
  assign wb1_v = rf.wb1_en_i && (rf.wb1_addr_i != '0);
  assign iss_v = rf.iss_en_i && (rf.iss_rd_i != '0);

  // Retire clears first so a same-cycle issue of the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb1_v) busy_d[rf.wb1_addr_i] = 1'b0;
    if (iss_v) busy_d[rf.iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_set = 1'b0;
    if (iss_v && busy_q[rf.iss_rd_i] && !(wb1_v && rf.wb1_addr_i == rf.iss_rd_i)) err_set = 1'b1;
    if (wb1_v && !busy_q[rf.wb1_addr_i]) err_set = 1'b1;
    if (wb0_v && busy_q[rf.wb0_addr_i]) err_set = 1'b1;
    if (wb0_v && wb1_v && rf.wb0_addr_i == rf.wb1_addr_i) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // wb0 is written last so it wins an address collision.
      if (wb1_v) mem_q[rf.wb1_addr_i] <= rf.wb1_data_i;
      if (wb0_v) mem_q[rf.wb0_addr_i] <= rf.wb0_data_i;
      busy_q <= busy_d;
      err_q  <= err_q | err_set;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rst_n && rf.rs1_addr_i != '0) begin
      if (rf.wb0_en_i && rf.wb0_addr_i == rf.rs1_addr_i)      rs1_data = rf.wb0_data_i;
      else if (rf.wb1_en_i && rf.wb1_addr_i == rf.rs1_addr_i) rs1_data = rf.wb1_data_i;
      else                                                     rs1_data = mem_q[rf.rs1_addr_i];
      rs1_busy = busy_q[rf.rs1_addr_i] && !(rf.wb1_en_i && rf.wb1_addr_i == rf.rs1_addr_i);
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rst_n && rf.rs2_addr_i != '0) begin
      if (rf.wb0_en_i && rf.wb0_addr_i == rf.rs2_addr_i)      rs2_data = rf.wb0_data_i;
      else if (rf.wb1_en_i && rf.wb1_addr_i == rf.rs2_addr_i) rs2_data = rf.wb1_data_i;
      else                                                     rs2_data = mem_q[rf.rs2_addr_i];
      rs2_busy = busy_q[rf.rs2_addr_i] && !(rf.wb1_en_i && rf.wb1_addr_i == rf.rs2_addr_i);
    end
  end

  assign rf.rs1_data_o = rs1_data;
  assign rf.rs2_data_o = rs2_data;
  assign rf.rs1_busy_o = rs1_busy;
  assign rf.rs2_busy_o = rs2_busy;
  assign rf.err_o      = err_q;

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed scenarios plus randomized traffic against an array-based model of the scoreboard.
module tb_regfile_sb;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG)) rf ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [31:0] m_regs [NREG];
  bit          m_busy [NREG];
  bit          m_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rf.iss_en_i   = 1'b0;
    rf.iss_rd_i   = '0;
    rf.wb0_en_i   = 1'b0;
    rf.wb0_addr_i = '0;
    rf.wb0_data_i = '0;
    rf.wb1_en_i   = 1'b0;
    rf.wb1_addr_i = '0;
    rf.wb1_data_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!rst_n || a == 0) return 32'h0;
    if (rf.wb0_en_i && rf.wb0_addr_i == a) return rf.wb0_data_i;
    if (rf.wb1_en_i && rf.wb1_addr_i == a) return rf.wb1_data_i;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n || a == 0) return 1'b0;
    if (rf.wb1_en_i && rf.wb1_addr_i == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_edge();
    bit w0, w1, is;
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        m_regs[i] = 0;
        m_busy[i] = 0;
      end
      m_err = 0;
      return;
    end
    w0 = rf.wb0_en_i && rf.wb0_addr_i != 0;
    w1 = rf.wb1_en_i && rf.wb1_addr_i != 0;
    is = rf.iss_en_i && rf.iss_rd_i != 0;
    if (is && m_busy[rf.iss_rd_i] && !(w1 && rf.wb1_addr_i == rf.iss_rd_i)) m_err = 1;
    if (w1 && !m_busy[rf.wb1_addr_i]) m_err = 1;
    if (w0 && m_busy[rf.wb0_addr_i]) m_err = 1;
    if (w0 && w1 && rf.wb0_addr_i == rf.wb1_addr_i) m_err = 1;
    if (w1) m_regs[rf.wb1_addr_i] = rf.wb1_data_i;
    if (w0) m_regs[rf.wb0_addr_i] = rf.wb0_data_i;
    if (w1) m_busy[rf.wb1_addr_i] = 0;
    if (is) m_busy[rf.iss_rd_i] = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rf.rs1_addr_i = 5'd5;
    rf.rs2_addr_i = 5'd5;
    #1;
    check_eq("rst_comb_data", rf.rs1_data_o, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("x5_data", rf.rs1_data_o, 0);
    check_eq("x5_busy", rf.rs1_busy_o, 0);
    check_eq("err_reset", rf.err_o, 0);

    // Forward from wb0, then read stored value
    @(negedge clk);
    rf.wb0_en_i = 1'b1; rf.wb0_addr_i = 5'd3; rf.wb0_data_i = 32'h1234_5678;
    rf.rs1_addr_i = 5'd3;
    #1;
    check_eq("x3_fwd", rf.rs1_data_o, 32'h1234_5678);
    tick();
    idle();
    #1;
    check_eq("x3_stored", rf.rs1_data_o, 32'h1234_5678);
    check_eq("x3_err", rf.err_o, 0);

    // Issue and retire x7
    @(negedge clk);
    rf.iss_en_i = 1'b1; rf.iss_rd_i = 5'd7;
    tick();
    idle();
    rf.rs2_addr_i = 5'd7;
    #1;
    check_eq("x7_busy", rf.rs2_busy_o, 1);
    rf.wb1_en_i = 1'b1; rf.wb1_addr_i = 5'd7; rf.wb1_data_i = 32'hDEAD_BEEF;
    #1;
    check_eq("x7_retire_busy", rf.rs2_busy_o, 0);
    check_eq("x7_retire_data", rf.rs2_data_o, 32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    check_eq("x7_after_busy", rf.rs2_busy_o, 0);
    check_eq("x7_after_data", rf.rs2_data_o, 32'hDEAD_BEEF);
    check_eq("x7_err", rf.err_o, 0);

    // Collision on x9
    rf.wb0_en_i = 1'b1; rf.wb0_addr_i = 5'd9; rf.wb0_data_i = 32'h1;
    rf.wb1_en_i = 1'b1; rf.wb1_addr_i = 5'd9; rf.wb1_data_i = 32'h2;
    rf.rs1_addr_i = 5'd9;
    #1;
    check_eq("x9_fwd", rf.rs1_data_o, 32'h1);
    tick();
    idle();
    #1;
    check_eq("x9_stored", rf.rs1_data_o, 32'h1);
    check_eq("x9_err", rf.err_o, 1);

    // Reset forces reads to zero combinationally, then x0 traffic
    rf.rs1_addr_i = 5'd3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_comb_x3", rf.rs1_data_o, 0);
    tick();
    rst_n = 1'b1;
    rf.wb0_en_i = 1'b1; rf.wb0_addr_i = 5'd0; rf.wb0_data_i = 32'hFFFF_FFFF;
    rf.wb1_en_i = 1'b1; rf.wb1_addr_i = 5'd0; rf.wb1_data_i = 32'hAAAA_AAAA;
    rf.iss_en_i = 1'b1; rf.iss_rd_i = 5'd0;
    rf.rs1_addr_i = 5'd0; rf.rs2_addr_i = 5'd0;
    #1;
    check_eq("x0_fwd", rf.rs1_data_o, 0);
    tick();
    idle();
    #1;
    check_eq("x0_data", rf.rs2_data_o, 0);
    check_eq("x0_busy", rf.rs2_busy_o, 0);
    check_eq("x0_err", rf.err_o, 0);
    check_eq("x3_cleared", 64'(dut.mem_q[3]), 0);

    // Pending op discarded by reset; its late write-back flags an error
    rf.iss_en_i = 1'b1; rf.iss_rd_i = 5'd4;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rf.wb1_en_i = 1'b1; rf.wb1_addr_i = 5'd4; rf.wb1_data_i = 32'hA5;
    rf.rs1_addr_i = 5'd4;
    tick();
    idle();
    #1;
    check_eq("x4_data", rf.rs1_data_o, 32'hA5);
    check_eq("x4_busy", rf.rs1_busy_o, 0);
    check_eq("x4_err", rf.err_o, 1);

    // Randomized traffic against the model
    rst_n = 1'b0;
    model_edge();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n         = ($urandom_range(0, 63) != 0);
      rf.rs1_addr_i = 5'($urandom_range(0, 7));
      rf.rs2_addr_i = 5'($urandom_range(0, 7));
      rf.iss_en_i   = ($urandom_range(0, 3) == 0);
      rf.iss_rd_i   = 5'($urandom_range(0, 7));
      rf.wb0_en_i   = ($urandom_range(0, 1) == 0);
      rf.wb0_addr_i = 5'($urandom_range(0, 7));
      rf.wb0_data_i = $urandom;
      rf.wb1_en_i   = ($urandom_range(0, 3) == 0);
      rf.wb1_addr_i = 5'($urandom_range(0, 7));
      rf.wb1_data_i = $urandom;
      #1;
      check_eq("rnd_rs1_data", rf.rs1_data_o, exp_data(rf.rs1_addr_i));
      check_eq("rnd_rs2_data", rf.rs2_data_o, exp_data(rf.rs2_addr_i));
      check_eq("rnd_rs1_busy", rf.rs1_busy_o, exp_busy(rf.rs1_addr_i));
      check_eq("rnd_rs2_busy", rf.rs2_busy_o, exp_busy(rf.rs2_addr_i));
      check_eq("rnd_err", rf.err_o, m_err);
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, 2..32); AW = log2(NREG).
REQ-003 SHALL have ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rs1_addr_i / rs2_addr_i  input  AW each  read addresses from ID.
- rs1_data_o / rs2_data_o  output  XLEN each  read data to ID.
- rs1_busy_o / rs2_busy_o  output  1 each  operand has a pending write; ID stalls.
- iss_en_i  input  1  issue of a long-latency op that will write iss_rd_i.
- iss_rd_i  input  AW  destination of the issued op.
- wb0_en_i, wb0_addr_i (AW), wb0_data_i (XLEN)  input  single-cycle EX write port.
- wb1_en_i, wb1_addr_i (AW), wb1_data_i (XLEN)  input  long-latency (load/mul-div) write port.
- err_o  output  1  sticky scoreboard protocol error.

Function
REQ-004 SHALL hold NREG registers of XLEN bits plus one busy bit per register.
REQ-005 Register 0 SHALL always read 0 and SHALL never be busy; writes and issues to address 0 SHALL be ignored.
REQ-006 Reads SHALL be combinational, zero-latency.
REQ-007 Read priority, per port: rst_n low -> 0; address 0 -> 0; wb0 enabled and wb0_addr equal to read address -> wb0_data_i; else wb1 enabled and address match -> wb1_data_i; else stored value.
REQ-008 Write: on a rising edge with rst_n high, wb0_en_i and wb1_en_i SHALL each write their data to nonzero addresses.
REQ-009 If both ports target the same nonzero address in one cycle, wb0 data SHALL be stored and err_o SHALL set.
REQ-010 Issue: iss_en_i with nonzero iss_rd_i SHALL set busy[iss_rd_i] on the next edge.
REQ-011 Retire: wb1_en_i with nonzero wb1_addr_i SHALL clear busy[wb1_addr_i] on the next edge; wb0 SHALL NOT change busy bits.
REQ-012 Same-cycle issue and wb1 retire of the same register: set SHALL win (register stays busy); the data SHALL still be written.
REQ-013 busy_o per port SHALL equal busy[addr], except: address 0 -> 0; wb1 retiring that address in the same cycle -> 0. The forwarded data SHALL be valid the same cycle.
REQ-014 err_o SHALL set on any of the following:
- issue to an already-busy register, unless it retires the same cycle;
- wb1 write to a non-busy nonzero register;
- wb0 write to a busy register (WAW hazard).
REQ-015 err_o SHALL stay set until reset; normal operation (writes, busy updates) SHALL proceed unchanged after an error.

Reset
REQ-016 While rst_n is low at a rising edge, registers 1..NREG-1 SHALL become 0, all busy bits SHALL become 0, and err_o SHALL become 0.
REQ-017 While rst_n is low, rs*_data_o and rs*_busy_o SHALL be 0 combinationally.
REQ-018 During reset, all write and issue inputs SHALL be ignored; a pending long-latency op is discarded, and its later wb1 arrival SHALL flag err_o.

Verification
REQ-019 SHALL cover the following directed scenarios:
- Reset, then read x5 -> data 0, busy 0, err_o 0.
- wb0 write x3=0x1234_5678 with rs1_addr=3 in the same cycle -> rs1_data=0x12345678 combinationally. Next cycle with wb0 idle -> still 0x12345678.
- Issue x7; next cycle rs2_addr=7 -> busy 1. wb1 write x7=0xDEAD_BEEF -> same cycle busy 0, data 0xDEADBEEF. Next cycle -> busy 0, stored value 0xDEADBEEF.
- Same cycle: wb0 and wb1 both write x9 (0x1 and 0x2) -> read gives 0x1; after the edge x9=0x1 and err_o=1.
- Writes and an issue to x0 -> reads of x0 return 0, busy 0, err_o 0.
- Issue x4, then assert rst_n low for one edge, then wb1 write x4=0xA5 -> x4=0xA5, busy 0, err_o=1.
